shift_add_multiplier: RTL

- Sequential unsigned N×N multiplier for the ALU datapath. It produces a 2N-bit product using one ripple-carry adder in radix-2 shift-add iterations, one iteration per clock.
- It sits directly upstream of the existing ripple-carry adder. It drives the adder's operands and carry-in every cycle and consumes the adder's sum and carry-out.
- Start/busy/done handshake to the control unit.

---
 rtl/shift_add_multiplier_pkg.sv | 11 +
 rtl/shift_add_multiplier_rca.sv | 24 ++
 rtl/shift_add_multiplier.sv | 96 +++++++++
 3 files changed

// File: rtl/shift_add_multiplier_pkg.sv
// Shared encodings for the multi-cycle ALU units.
// S_RUN and S_DONE are also used by other sequencers.
package shift_add_multiplier_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_multiplier_rca.sv
// Ripple-carry adder of parameterisable width.
// The carry propagates bit by bit from the carry-in to the carry-out.
module RCA_8bit #(
  parameter int n = 8
) (
  input  logic [n-1:0] i_a,
  input  logic [n-1:0] i_b,
  input  logic         i_cin,
  output logic [n-1:0] o_sum,
  output logic         o_cout
);

  always_comb begin
    logic c;
    c      = i_cin;
    o_sum  = '0;
    for (int i = 0; i < n; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ c;
      c        = (i_a[i] & i_b[i]) | (c & (i_a[i] ^ i_b[i]));
    end
    o_cout = c;
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned NxN radix-2 shift-add multiplier with a start/busy/done
// handshake. One adder iteration per clock; N iterations per product.
//
// state  | meaning
// S_IDLE | waiting for start
// S_RUN  | iterating: add (Q[0] ? M : 0) to ACC, shift {cout,ACC,Q} right
// S_DONE | product valid, done pulse; start here is accepted back-to-back
module shift_add_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);
  import shift_add_multiplier_pkg::*;

  localparam int CW = $clog2(N + 1);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [N-1:0]   r_m;
  logic [N-1:0]   r_acc;
  logic [N-1:0]   r_q;
  logic [CW-1:0]  r_count;
  logic [2*N-1:0] r_product;
  logic [N-1:0]   w_addend;
  logic [N-1:0]   w_sum;
  logic           w_cout;
  logic           w_accept;
  logic           w_last;

  assign w_addend = r_q[0] ? r_m : '0;
  assign w_accept = start && (r_state != S_RUN);
  assign w_last   = (r_count == CW'(N - 1));

  RCA_8bit #(.n(N)) u_rca (
    .i_a    (r_acc),
    .i_b    (w_addend),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = start ? S_RUN : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The carry-out is the top bit of the shifted value; dropping it would
  // corrupt any step where ACC + M overflows N bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m       <= '0;
      r_acc     <= '0;
      r_q       <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_m     <= multiplicand;
      r_acc   <= '0;
      r_q     <= multiplier;
      r_count <= '0;
    end else if (r_state == S_RUN) begin
      r_acc   <= {w_cout, w_sum[N-1:1]};
      r_q     <= {w_sum[0], r_q[N-1:1]};
      r_count <= r_count + 1'b1;
      if (w_last) r_product <= {w_cout, w_sum, r_q[N-1:1]};
    end
  end

  assign product = r_product;

endmodule
